ldpc_varnode_update: RTL and testbench

- Variable-node update for the min-sum LDPC decoder. It is the counterpart of the check-node min/sign stage.
- For one variable node it accepts the channel LLR, then a serial stream of check-to-variable messages (one per edge).
- It accumulates the posterior total and emits one extrinsic variable-to-check message per edge, plus a hard-decision bit.
- It sits between the check-node message memory and the next check-node pass.

---
 rtl/ldpc_varnode_update.sv | 129 ++++++++++++
 tb/tb_ldpc_varnode_update.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ldpc_varnode_update.sv
// ldpc_varnode_update: min-sum variable-node update that sums the channel LLR and the
// check-to-variable messages, then streams one extrinsic message per edge and a hard decision.
module ldpc_varnode_update #(
    parameter int WIDTH     = 8,
    parameter int MAX_DEG   = 6,
    parameter int ACC_WIDTH = WIDTH + 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_chan_llr,
    input  logic             i_chan_valid,
    output logic             o_chan_ready,
    input  logic [WIDTH-1:0] i_msg_data,
    input  logic             i_msg_valid,
    input  logic             i_msg_last,
    output logic             o_msg_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_out_last,
    input  logic             i_out_ready,
    output logic             o_hard_bit,
    output logic             o_hard_valid,
    output logic             o_error
);
    localparam int CW = $clog2(MAX_DEG + 1);
    localparam logic [WIDTH-1:0] MIN_RAW = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_SYM = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_SYM = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MAX_ACC = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_ACC = -MAX_ACC;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] chan_ext;
    logic signed [ACC_WIDTH-1:0] msg_ext;
    logic signed [ACC_WIDTH-1:0] buf_ext;
    logic signed [ACC_WIDTH-1:0] diff;
    logic [WIDTH-1:0]            chan_c;
    logic [WIDTH-1:0]            msg_c;
    logic [WIDTH-1:0]            buffer [MAX_DEG];
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               cnt_final;
    logic [CW-1:0]               k;
    logic                        full;
    logic                        chan_hs;
    logic                        msg_hs;
    logic                        out_hs;

    // The most negative code is folded onto -(2^(WIDTH-1)-1) so magnitudes are symmetric.
    assign chan_c    = (i_chan_llr == MIN_RAW) ? MIN_SYM : i_chan_llr;
    assign msg_c     = (i_msg_data == MIN_RAW) ? MIN_SYM : i_msg_data;
    assign chan_ext  = {{(ACC_WIDTH-WIDTH){chan_c[WIDTH-1]}}, chan_c};
    assign msg_ext   = {{(ACC_WIDTH-WIDTH){msg_c[WIDTH-1]}}, msg_c};
    assign buf_ext   = {{(ACC_WIDTH-WIDTH){buffer[k][WIDTH-1]}}, buffer[k]};
    assign full      = cnt == CW'(MAX_DEG);
    assign acc_next  = full ? acc : acc + msg_ext;
    assign cnt_final = full ? cnt : cnt + CW'(1);
    assign diff      = acc - buf_ext;
    assign chan_hs   = i_chan_valid & o_chan_ready;
    assign msg_hs    = i_msg_valid & o_msg_ready;
    assign out_hs    = o_out_valid & i_out_ready;

    // Extrinsic value is derived from held registers, so it stays stable under backpressure.
    always_comb begin
        o_out_data = !o_out_valid ? '0 :
                     diff > MAX_ACC ? MAX_SYM :
                     diff < MIN_ACC ? -MAX_SYM : diff[WIDTH-1:0];
    end

    always_ff @(posedge i_clock) begin
        if (state == ACCUM && msg_hs && !full) buffer[cnt] <= msg_c;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            k            <= '0;
            o_error      <= 1'b0;
            o_hard_bit   <= 1'b0;
            o_hard_valid <= 1'b0;
            o_out_valid  <= 1'b0;
            o_out_last   <= 1'b0;
            o_chan_ready <= 1'b1;
            o_msg_ready  <= 1'b0;
        end else begin
            o_hard_valid <= 1'b0;
            case (state)
                IDLE: if (chan_hs) begin
                    acc          <= chan_ext;
                    cnt          <= '0;
                    state        <= ACCUM;
                    o_chan_ready <= 1'b0;
                    o_msg_ready  <= 1'b1;
                end
                ACCUM: if (msg_hs) begin
                    acc <= acc_next;
                    cnt <= cnt_final;
                    if (full) o_error <= 1'b1;
                    if (i_msg_last) begin
                        state        <= EMIT;
                        k            <= '0;
                        o_msg_ready  <= 1'b0;
                        o_hard_valid <= 1'b1;
                        o_hard_bit   <= acc_next[ACC_WIDTH-1];
                        o_out_valid  <= 1'b1;
                        o_out_last   <= cnt_final == CW'(1);
                    end
                end
                EMIT: if (out_hs) begin
                    if (o_out_last) begin
                        state        <= IDLE;
                        o_out_valid  <= 1'b0;
                        o_out_last   <= 1'b0;
                        o_chan_ready <= 1'b1;
                    end else begin
                        k          <= k + CW'(1);
                        o_out_last <= k + CW'(2) == cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_varnode_update.sv
// tb_ldpc_varnode_update: directed vectors with hand-computed extrinsic outputs,
// hard decisions, backpressure, degree overflow and mid-stream reset.
module tb_ldpc_varnode_update;
    logic       i_clock = 0;
    logic       i_reset = 0;
    logic [7:0] i_chan_llr = '0;
    logic       i_chan_valid = 0;
    logic       o_chan_ready;
    logic [7:0] i_msg_data = '0;
    logic       i_msg_valid = 0;
    logic       i_msg_last = 0;
    logic       o_msg_ready;
    logic [7:0] o_out_data;
    logic       o_out_valid;
    logic       o_out_last;
    logic       i_out_ready = 1;
    logic       o_hard_bit;
    logic       o_hard_valid;
    logic       o_error;

    int n_tests = 0;
    int n_fail  = 0;

    ldpc_varnode_update #(.WIDTH(8), .MAX_DEG(6)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_chan_llr(i_chan_llr), .i_chan_valid(i_chan_valid), .o_chan_ready(o_chan_ready),
        .i_msg_data(i_msg_data), .i_msg_valid(i_msg_valid), .i_msg_last(i_msg_last),
        .o_msg_ready(o_msg_ready),
        .o_out_data(o_out_data), .o_out_valid(o_out_valid), .o_out_last(o_out_last),
        .i_out_ready(i_out_ready),
        .o_hard_bit(o_hard_bit), .o_hard_valid(o_hard_valid), .o_error(o_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_chan(input int v);
        int n = 0;
        logic [31:0] w = v;
        i_chan_llr   = w[7:0];
        i_chan_valid = 1;
        while (!o_chan_ready && n < 20) begin step(); n++; end
        check("chan_ready", int'(o_chan_ready), 1);
        step();
        i_chan_valid = 0;
        i_msg_valid  = 0;
        i_msg_last   = 0;
    endtask

    task automatic send_msg(input int v, input logic last);
        int n = 0;
        logic [31:0] w = v;
        i_msg_data  = w[7:0];
        i_msg_last  = last;
        i_msg_valid = 1;
        while (!o_msg_ready && n < 20) begin step(); n++; end
        check("msg_ready", int'(o_msg_ready), 1);
        step();
        i_msg_valid = 0;
        i_msg_last  = 0;
    endtask

    task automatic recv(input int exp, input int exp_last);
        check("out_valid", int'(o_out_valid), 1);
        check("out_data", int'($signed(o_out_data)), exp);
        check("out_last", int'(o_out_last), exp_last);
        step();
    endtask

    task automatic check_hard(input int exp);
        check("lat_valid", int'(o_out_valid), 1);
        check("hard_valid", int'(o_hard_valid), 1);
        check("hard_bit", int'(o_hard_bit), exp);
    endtask

    initial begin
        step(); step();
        check("rst_chan_ready", int'(o_chan_ready), 1);
        check("rst_msg_ready", int'(o_msg_ready), 0);
        check("rst_out_valid", int'(o_out_valid), 0);
        check("rst_hard_valid", int'(o_hard_valid), 0);
        check("rst_error", int'(o_error), 0);
        check("rst_out_data", int'(o_out_data), 0);
        i_reset = 1;
        step();

        // Basic; a message offered alongside the channel LLR must be ignored.
        i_msg_data = 8'd50; i_msg_last = 1; i_msg_valid = 1;
        check("idle_msg_ready", int'(o_msg_ready), 0);
        send_chan(10);
        send_msg(3, 0); send_msg(-5, 0); send_msg(7, 1);
        check_hard(0);
        recv(12, 0);
        check("hard_strobe_once", int'(o_hard_valid), 0);
        recv(20, 0); recv(8, 1);
        check("basic_chan_ready", int'(o_chan_ready), 1);
        check("basic_out_valid", int'(o_out_valid), 0);

        // Saturation
        send_chan(100);
        send_msg(100, 0); send_msg(100, 1);
        check_hard(0);
        recv(127, 0); recv(127, 1);

        // Clamp and negative total
        send_chan(-128);
        send_msg(-20, 1);
        check_hard(1);
        recv(-127, 1);

        // Backpressure on the second output
        send_chan(10);
        send_msg(3, 0); send_msg(-5, 0); send_msg(7, 1);
        recv(12, 0);
        i_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", int'(o_out_valid), 1);
            check("bp_data", int'($signed(o_out_data)), 20);
            check("bp_last", int'(o_out_last), 0);
            check("bp_msg_ready", int'(o_msg_ready), 0);
            check("bp_chan_ready", int'(o_chan_ready), 0);
            step();
        end
        i_out_ready = 1;
        recv(20, 0); recv(8, 1);

        // Degree overflow: seventh message dropped
        send_chan(0);
        for (int i = 0; i < 6; i++) send_msg(1, 0);
        check("ovf_error_pre", int'(o_error), 0);
        send_msg(1, 1);
        check("ovf_error", int'(o_error), 1);
        check_hard(0);
        for (int i = 0; i < 6; i++) recv(5, i == 5 ? 1 : 0);
        check("ovf_error_sticky", int'(o_error), 1);
        check("ovf_chan_ready", int'(o_chan_ready), 1);

        // Reset mid-EMIT
        send_chan(10);
        send_msg(3, 0); send_msg(-5, 0); send_msg(7, 1);
        recv(12, 0);
        i_reset = 0;
        step();
        check("mid_out_valid", int'(o_out_valid), 0);
        check("mid_hard_valid", int'(o_hard_valid), 0);
        check("mid_error", int'(o_error), 0);
        check("mid_chan_ready", int'(o_chan_ready), 1);
        check("mid_msg_ready", int'(o_msg_ready), 0);
        i_reset = 1;
        step();
        send_chan(1);
        send_msg(2, 1);
        check_hard(0);
        recv(1, 1);
        check("end_chan_ready", int'(o_chan_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
